// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic-array job sequencer: default geometry,
// derived address widths, FSM state encoding and the {WRITE,LOAD} mode-pin pairs.
package systolic_pkg;

   localparam int SA_N             = 8;
   localparam int SA_DW            = 16;
   localparam int SA_LOAD_CYCLES   = 8;
   localparam int SA_MATMUL_CYCLES = 23;
   localparam int SA_READ_LAT      = 1;

   localparam int REG_COUNT    = 2 * SA_N;
   localparam int WORD_COUNT   = 2 * SA_N * SA_N;
   localparam int RESULT_COUNT = SA_N * SA_N;

   localparam int IDX_W  = $clog2(SA_N);
   localparam int REG_W  = $clog2(REG_COUNT);
   localparam int WORD_W = $clog2(WORD_COUNT);
   localparam int RES_W  = $clog2(RESULT_COUNT);

   // {WRITE,LOAD}; MODE_MATMUL doubles as the all-quiet pin state outside a job.
   localparam logic [1:0] MODE_WRITE  = 2'b10;
   localparam logic [1:0] MODE_LOAD   = 2'b01;
   localparam logic [1:0] MODE_MATMUL = 2'b00;
   localparam logic [1:0] MODE_READ   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FILL      = 3'd1,
      ST_LOAD      = 3'd2,
      ST_MATMUL    = 3'd3,
      ST_READ_ADDR = 3'd4,
      ST_READ_WAIT = 3'd5,
      ST_READ_OUT  = 3'd6,
      ST_FIN       = 3'd7
   } seq_state_t;

endpackage

// File: rtl/seq_phase_counter.sv
// Loadable down-counter with terminal-count flag; times the LOAD, MATMUL and READ_WAIT phases.
module seq_phase_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count;

   // Parks at zero so tc stays asserted until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Runs one full 8x8 matmul job on the systolic array: streams operands in, sequences
// LOAD and MATMUL, then reads the N*N results back out tagged with row and column.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int N             = SA_N,
   parameter int DW            = SA_DW,
   parameter int LOAD_CYCLES   = SA_LOAD_CYCLES,
   parameter int MATMUL_CYCLES = SA_MATMUL_CYCLES,
   parameter int READ_LAT      = SA_READ_LAT
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     START,
   output logic                     BUSY,
   output logic                     DONE,
   input  logic [DW-1:0]            IN_DATA,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   output logic [DW-1:0]            RES_DATA,
   output logic                     RES_VALID,
   input  logic                     RES_READY,
   output logic [$clog2(N)-1:0]     RES_ROW,
   output logic [$clog2(N)-1:0]     RES_COL,
   output logic                     SA_EN,
   output logic                     SA_WRITE,
   output logic                     SA_LOAD,
   output logic [$clog2(2*N)-1:0]   SA_REG,
   output logic [$clog2(N)-1:0]     SA_IDX,
   output logic [DW-1:0]            SA_DATA_IN,
   input  logic [DW-1:0]            SA_DATA_OUT,
   output logic [2:0]               DBG_STATE
);

   localparam int IW      = $clog2(N);
   localparam int RW      = $clog2(2 * N);
   localparam int WCW     = $clog2(2 * N * N);
   localparam int RIW     = $clog2(N * N);
   localparam int WORDS   = 2 * N * N;
   localparam int RESULTS = N * N;
   localparam int PH_MAX  = (LOAD_CYCLES > MATMUL_CYCLES)
                            ? ((LOAD_CYCLES > READ_LAT) ? LOAD_CYCLES : READ_LAT)
                            : ((MATMUL_CYCLES > READ_LAT) ? MATMUL_CYCLES : READ_LAT);
   localparam int PW      = $clog2(PH_MAX + 1);

   seq_state_t     state;
   logic [WCW-1:0] word_cnt;
   logic [RIW-1:0] res_idx;
   logic [1:0]     mode;
   logic           sa_en_r;
   logic           in_ready;
   logic           busy;
   logic           done;
   logic           res_valid;
   logic [DW-1:0]  res_data;
   logic [IW-1:0]  res_row;
   logic [IW-1:0]  res_col;

   logic           fill_xfer;
   logic           last_word;
   logic           last_res;
   logic           ph_load;
   logic [PW-1:0]  ph_val;
   logic           ph_tc;

   // Both streams transfer on a rising edge where valid and ready are both high; a
   // producer holds its word stable while valid is high and ready is low.
   assign fill_xfer = IN_VALID & in_ready;
   assign last_word = (word_cnt == WCW'(WORDS - 1));
   assign last_res  = (res_idx == RIW'(RESULTS - 1));

   always_comb begin
      ph_load = 1'b0;
      ph_val  = '0;
      case (state)
         ST_FILL: begin
            if (fill_xfer && last_word) begin
               ph_load = 1'b1;
               ph_val  = PW'(LOAD_CYCLES - 1);
            end
         end
         ST_LOAD: begin
            if (ph_tc) begin
               ph_load = 1'b1;
               ph_val  = PW'(MATMUL_CYCLES - 1);
            end
         end
         ST_READ_ADDR: begin
            ph_load = 1'b1;
            ph_val  = PW'(READ_LAT - 1);
         end
         default: ;
      endcase
   end

   seq_phase_counter #(.W(PW)) u_phase (
      .clk      (CLK),
      .rst      (RST),
      .load     (ph_load),
      .load_val (ph_val),
      .tc       (ph_tc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         word_cnt  <= '0;
         res_idx   <= '0;
         mode      <= MODE_MATMUL;
         sa_en_r   <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_row   <= '0;
         res_col   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  state    <= ST_FILL;
                  word_cnt <= '0;
                  in_ready <= 1'b1;
                  mode     <= MODE_WRITE;
                  busy     <= 1'b1;
               end
            end
            ST_FILL: begin
               if (fill_xfer) begin
                  word_cnt <= word_cnt + 1'b1;
                  if (last_word) begin
                     state    <= ST_LOAD;
                     in_ready <= 1'b0;
                     sa_en_r  <= 1'b1;
                     mode     <= MODE_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (ph_tc) begin
                  state <= ST_MATMUL;
                  mode  <= MODE_MATMUL;
               end
            end
            ST_MATMUL: begin
               if (ph_tc) begin
                  state   <= ST_READ_ADDR;
                  mode    <= MODE_READ;
                  res_idx <= '0;
               end
            end
            ST_READ_ADDR: state <= ST_READ_WAIT;
            ST_READ_WAIT: begin
               if (ph_tc) begin
                  res_data  <= SA_DATA_OUT;
                  res_row   <= res_idx[RIW-1:IW];
                  res_col   <= res_idx[IW-1:0];
                  res_valid <= 1'b1;
                  state     <= ST_READ_OUT;
               end
            end
            ST_READ_OUT: begin
               if (RES_READY) begin
                  res_valid <= 1'b0;
                  if (last_res) begin
                     state   <= ST_FIN;
                     done    <= 1'b1;
                     sa_en_r <= 1'b0;
                     mode    <= MODE_MATMUL;
                  end else begin
                     res_idx <= res_idx + 1'b1;
                     state   <= ST_READ_ADDR;
                  end
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Array addressing follows the fill word counter, then the result index during readout.
   always_comb begin
      SA_REG = '0;
      SA_IDX = '0;
      case (state)
         ST_FILL: begin
            SA_REG = word_cnt[WCW-1:IW];
            SA_IDX = word_cnt[IW-1:0];
         end
         ST_READ_ADDR, ST_READ_WAIT, ST_READ_OUT: begin
            SA_REG = RW'(res_idx[RIW-1:IW]);
            SA_IDX = res_idx[IW-1:0];
         end
         default: ;
      endcase
   end

   assign SA_EN      = (state == ST_FILL) ? IN_VALID : sa_en_r;
   assign SA_WRITE   = mode[1];
   assign SA_LOAD    = mode[0];
   assign SA_DATA_IN = (state == ST_FILL) ? IN_DATA : '0;
   assign IN_READY   = in_ready;
   assign BUSY       = busy;
   assign DONE       = done;
   assign RES_VALID  = res_valid;
   assign RES_DATA   = res_data;
   assign RES_ROW    = res_row;
   assign RES_COL    = res_col;
   assign DBG_STATE  = state;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: behavioural array model plus a result scoreboard fed from
// the operand matrices the bench streams in.
module tb_systolic_seq_ctrl;
   import systolic_pkg::*;

   localparam int N       = 8;
   localparam int DW      = 16;
   localparam int LOAD_C  = 8;
   localparam int MM_C    = 23;
   localparam int RL      = 1;
   localparam int W       = DW + 6;
   localparam int MIN_LAT = 2 * N * N + LOAD_C + MM_C + N * N * (2 + RL) + 1;

   logic          CLK = 1'b0;
   logic          RST, START, IN_VALID, RES_READY;
   logic [DW-1:0] IN_DATA;
   logic [DW-1:0] SA_DATA_OUT;
   logic          BUSY, DONE, IN_READY, RES_VALID, SA_EN, SA_WRITE, SA_LOAD;
   logic [DW-1:0] RES_DATA, SA_DATA_IN;
   logic [2:0]    RES_ROW, RES_COL, SA_IDX, DBG_STATE;
   logic [3:0]    SA_REG;

   systolic_seq_ctrl dut (
      .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
      .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .RES_DATA(RES_DATA), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_ROW(RES_ROW), .RES_COL(RES_COL),
      .SA_EN(SA_EN), .SA_WRITE(SA_WRITE), .SA_LOAD(SA_LOAD), .SA_REG(SA_REG),
      .SA_IDX(SA_IDX), .SA_DATA_IN(SA_DATA_IN), .SA_DATA_OUT(SA_DATA_OUT),
      .DBG_STATE(DBG_STATE)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- array model ----------------
   logic [DW-1:0] mem [16][8];
   logic [DW-1:0] rf  [16][8];
   int            wr_cnt = 0, ld_cnt = 0, mm_cnt = 0;
   logic [3:0]    last_reg;
   logic [2:0]    last_idx;
   logic [DW-1:0] last_dat;

   function automatic logic [DW-1:0] dot(input logic [3:0] r, input logic [2:0] c);
      logic [DW-1:0] s;
      s = '0;
      for (int k = 0; k < N; k++) s = s + rf[r][k] * rf[8 + c][k];
      return s;
   endfunction

   always @(posedge CLK) begin
      if (SA_EN && SA_WRITE && !SA_LOAD) begin
         mem[SA_REG][SA_IDX] <= SA_DATA_IN;
         wr_cnt   <= wr_cnt + 1;
         last_reg <= SA_REG;
         last_idx <= SA_IDX;
         last_dat <= SA_DATA_IN;
      end
      if (SA_EN && !SA_WRITE && SA_LOAD) begin
         rf     <= mem;
         ld_cnt <= ld_cnt + 1;
      end
      if (SA_EN && !SA_WRITE && !SA_LOAD) mm_cnt <= mm_cnt + 1;
      if (SA_EN && SA_WRITE && SA_LOAD) SA_DATA_OUT <= dot(SA_REG, SA_IDX);
      else SA_DATA_OUT <= 16'hdead;
   end

   // ---------------- scoreboard state ----------------
   logic [DW-1:0] op [16][8];
   logic [W-1:0]  exp_q [$];
   int            errors = 0, checks = 0;
   int            n_res, n_done, busy_cyc;
   int            w0, l0, m0;

   // ---------------- driver tasks ----------------
   task automatic set_ramp();
      for (int r = 0; r < 2 * N; r++)
         for (int k = 0; k < N; k++) op[r][k] = DW'(k + 1);
   endtask

   task automatic set_random();
      for (int r = 0; r < 2 * N; r++)
         for (int k = 0; k < N; k++) op[r][k] = DW'($urandom_range(0, 9));
   endtask

   task automatic push_expected(input bit ramp);
      logic [DW-1:0] s;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            if (ramp) s = 16'd204;
            else begin
               s = '0;
               for (int k = 0; k < N; k++) s = s + op[i][k] * op[N + j][k];
            end
            exp_q.push_back({s, 3'(i), 3'(j)});
         end
   endtask

   task automatic snapshot();
      w0 = wr_cnt; l0 = ld_cnt; m0 = mm_cnt;
   endtask

   task automatic run_job(input bit toggle_in, input int hold_idx, input int hold_len,
                          input bit start_glitch, input int abort_mm);
      int           wi, cyc, held, mm_seen;
      bit           fin;
      logic [W-1:0] e, hold_v, got;
      n_res = 0; n_done = 0; busy_cyc = 0;
      wi = 0; cyc = 0; held = 0; mm_seen = 0; fin = 0; hold_v = '0;
      @(negedge CLK);
      START = 1'b1;
      while (!fin && cyc < 3000) begin
         @(negedge CLK);
         cyc++;
         START = 1'b0;
         if (BUSY) busy_cyc++;
         if (DONE) begin
            n_done++;
            fin = 1;
            checks++;
            if (n_res != N * N) begin
               errors++;
               $display("FAIL done_timing: results accepted before DONE=%0d required=%0d", n_res, N * N);
            end
         end
         if (wi < 2 * N * N && (!toggle_in || cyc[0])) begin
            IN_VALID = 1'b1;
            IN_DATA  = op[wi / N][wi % N];
            if (IN_READY) wi++;
         end else begin
            IN_VALID = 1'b0;
            IN_DATA  = DW'($urandom);
         end
         RES_READY = 1'b1;
         got = {RES_DATA, RES_ROW, RES_COL};
         if (RES_VALID && n_res == hold_idx && held < hold_len) begin
            if (held == 0) hold_v = got;
            else begin
               checks++;
               if (got !== hold_v) begin
                  errors++;
                  $display("FAIL hold_stable: got %h required %h", got, hold_v);
               end
            end
            held++;
            RES_READY = 1'b0;
         end
         if (RES_VALID && RES_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL result_extra: got data=%0d row=%0d col=%0d required none", RES_DATA, RES_ROW, RES_COL);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL result[%0d]: got data=%0d row=%0d col=%0d required data=%0d row=%0d col=%0d",
                           n_res, RES_DATA, RES_ROW, RES_COL, e[W-1:6], e[5:3], e[2:0]);
               end
            end
            n_res++;
         end
         if (start_glitch && (DBG_STATE == ST_MATMUL || (DBG_STATE == ST_READ_OUT && n_res == 20)))
            START = 1'b1;
         if (abort_mm > 0 && DBG_STATE == ST_MATMUL) begin
            mm_seen++;
            if (mm_seen == abort_mm) begin
               RST = 1'b1;
               fin = 1;
            end
         end
      end
      IN_VALID = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL job_timeout: got no DONE within %0d cycles required DONE", cyc);
      end
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      RST = 1'b1; START = 1'b0; IN_VALID = 1'b1; IN_DATA = 16'h1234; RES_READY = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      checks++;
      if (DBG_STATE !== ST_IDLE) begin
         errors++; $display("FAIL reset_state: got %0d required %0d", DBG_STATE, ST_IDLE);
      end
      checks++;
      if ({BUSY, DONE, IN_READY, RES_VALID, SA_EN, SA_WRITE, SA_LOAD} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0", {BUSY, DONE, IN_READY, RES_VALID, SA_EN, SA_WRITE, SA_LOAD});
      end
      checks++;
      if ({RES_DATA, RES_ROW, RES_COL, SA_REG, SA_IDX, SA_DATA_IN} !== '0) begin
         errors++;
         $display("FAIL reset_data: got res=%h row=%0d col=%0d reg=%0d idx=%0d din=%h required 0",
                  RES_DATA, RES_ROW, RES_COL, SA_REG, SA_IDX, SA_DATA_IN);
      end
      IN_VALID = 1'b0;
   endtask

   task automatic test_ramp();
      set_ramp();
      push_expected(1);
      snapshot();
      run_job(0, -1, 0, 0, 0);
      checks++;
      if (n_done != 1) begin errors++; $display("FAIL ramp_done: got %0d required 1", n_done); end
      checks++;
      if (busy_cyc != MIN_LAT) begin errors++; $display("FAIL ramp_latency: got %0d required %0d", busy_cyc, MIN_LAT); end
      checks++;
      if (wr_cnt - w0 != 2 * N * N) begin errors++; $display("FAIL ramp_writes: got %0d required %0d", wr_cnt - w0, 2 * N * N); end
      checks++;
      if (ld_cnt - l0 != LOAD_C) begin errors++; $display("FAIL ramp_load_len: got %0d required %0d", ld_cnt - l0, LOAD_C); end
      checks++;
      if (mm_cnt - m0 != MM_C) begin errors++; $display("FAIL ramp_mm_len: got %0d required %0d", mm_cnt - m0, MM_C); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL ramp_missing: got %0d left required 0", exp_q.size()); end
      @(negedge CLK);
      checks++;
      if ({DONE, BUSY} !== 2'b00 || DBG_STATE !== ST_IDLE) begin
         errors++; $display("FAIL ramp_after_fin: got done=%b busy=%b state=%0d required 0 0 0", DONE, BUSY, DBG_STATE);
      end
   endtask

   task automatic test_random();
      set_random();
      push_expected(0);
      snapshot();
      run_job(0, -1, 0, 0, 0);
      checks++;
      if (n_done != 1 || exp_q.size() != 0) begin
         errors++; $display("FAIL random_job: got done=%0d left=%0d required 1 0", n_done, exp_q.size());
      end
      checks++;
      if ({last_reg, last_idx} !== {4'd15, 3'd7} || last_dat !== op[15][7]) begin
         errors++;
         $display("FAIL random_last_write: got reg=%0d idx=%0d data=%0d required 15 7 %0d", last_reg, last_idx, last_dat, op[15][7]);
      end
      checks++;
      if (wr_cnt - w0 != 2 * N * N) begin errors++; $display("FAIL random_writes: got %0d required %0d", wr_cnt - w0, 2 * N * N); end
   endtask

   task automatic test_in_backpressure();
      push_expected(0);
      snapshot();
      run_job(1, -1, 0, 0, 0);
      checks++;
      if (wr_cnt - w0 != 2 * N * N) begin errors++; $display("FAIL inbp_writes: got %0d required %0d", wr_cnt - w0, 2 * N * N); end
      checks++;
      if (n_done != 1 || exp_q.size() != 0) begin
         errors++; $display("FAIL inbp_job: got done=%0d left=%0d required 1 0", n_done, exp_q.size());
      end
   endtask

   task automatic test_out_backpressure();
      push_expected(0);
      run_job(0, 10, 5, 0, 0);
      checks++;
      if (n_done != 1 || n_res != N * N || exp_q.size() != 0) begin
         errors++; $display("FAIL outbp_job: got done=%0d res=%0d left=%0d required 1 64 0", n_done, n_res, exp_q.size());
      end
      checks++;
      if (busy_cyc != MIN_LAT + 5) begin errors++; $display("FAIL outbp_latency: got %0d required %0d", busy_cyc, MIN_LAT + 5); end
   endtask

   task automatic test_start_ignored();
      push_expected(0);
      snapshot();
      run_job(0, -1, 0, 1, 0);
      checks++;
      if (ld_cnt - l0 != LOAD_C || mm_cnt - m0 != MM_C) begin
         errors++; $display("FAIL start_phase_len: got load=%0d mm=%0d required %0d %0d", ld_cnt - l0, mm_cnt - m0, LOAD_C, MM_C);
      end
      checks++;
      if (n_done != 1 || busy_cyc != MIN_LAT || exp_q.size() != 0) begin
         errors++; $display("FAIL start_ignored: got done=%0d busy=%0d left=%0d required 1 %0d 0", n_done, busy_cyc, exp_q.size(), MIN_LAT);
      end
   endtask

   task automatic test_abort();
      set_ramp();
      push_expected(1);
      run_job(0, -1, 0, 0, 12);
      @(negedge CLK);
      checks++;
      if (DBG_STATE !== ST_IDLE || n_done != 0) begin
         errors++; $display("FAIL abort_state: got state=%0d done=%0d required 0 0", DBG_STATE, n_done);
      end
      checks++;
      if ({BUSY, DONE, IN_READY, RES_VALID, SA_EN, SA_WRITE, SA_LOAD, SA_REG, SA_IDX, SA_DATA_IN, RES_DATA} !== '0) begin
         errors++; $display("FAIL abort_outputs: got busy=%b en=%b wr=%b ld=%b reg=%0d required 0", BUSY, SA_EN, SA_WRITE, SA_LOAD, SA_REG);
      end
      exp_q.delete();
      RST = 1'b0;
      @(negedge CLK);
      set_random();
      push_expected(0);
      run_job(0, -1, 0, 0, 0);
      checks++;
      if (n_done != 1 || exp_q.size() != 0) begin
         errors++; $display("FAIL abort_rerun: got done=%0d left=%0d required 1 0", n_done, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      set_ramp();
      push_expected(1);
      run_job(0, -1, 0, 0, 0);
      set_random();
      push_expected(0);
      run_job(0, -1, 0, 0, 0);
      checks++;
      if (n_done != 1 || busy_cyc != MIN_LAT || exp_q.size() != 0) begin
         errors++; $display("FAIL b2b_second: got done=%0d busy=%0d left=%0d required 1 %0d 0", n_done, busy_cyc, exp_q.size(), MIN_LAT);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_ramp();
      test_random();
      test_in_backpressure();
      test_out_backpressure();
      test_start_ignored();
      test_abort();
      test_back_to_back();
      repeat (2) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
